snapshot_capture_ctrl: RTL and testbench



---
 rtl/snapshot_pkg.sv | 17 +
 rtl/snapshot_capture_ctrl.sv | 98 +++++++++
 tb/tb_snapshot_capture_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snapshot_pkg.sv
// Shared types and bit positions for the gbe1 RX snapshot capture controller.
package snapshot_pkg;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  // Control word bit positions
  localparam int unsigned ARM      = 0;
  localparam int unsigned SW_TRIG  = 1;
  localparam int unsigned WE_FORCE = 2;
  localparam int unsigned LEN_LSB  = 16;

  // Status word bit positions
  localparam int unsigned DONE  = 31;
  localparam int unsigned ARMED = 30;
  localparam int unsigned CAPT  = 29;

endpackage

// File: rtl/snapshot_capture_ctrl.sv
// Snapshot capture controller: arm on a rising arm bit, wait for a trigger, then write
// len_m1 + 1 words into the snapshot BRAM and report progress in a status word.
module snapshot_capture_ctrl
  import snapshot_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [31:0]           ctrl,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  we_in,
  input  logic                  trig_in,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_data,
  output logic                  bram_we,
  output logic [31:0]           status
);

  localparam logic [ADDR_WIDTH:0] CountOne = 1;

  logic [31:0]           ctrl_r;
  logic                  arm_d;
  state_e                state;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH:0]   count;

  logic                  arm_rise;
  logic                  wr;
  logic                  trig;
  logic                  do_write;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] len_m1;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           status_d;
  logic                  unused_ctrl;

  assign arm_rise  = ctrl_r[ARM] & ~arm_d;
  assign wr        = we_in | ctrl_r[WE_FORCE];
  assign trig      = trig_in | ctrl_r[SW_TRIG];
  assign len_m1    = ctrl_r[LEN_LSB +: ADDR_WIDTH];
  assign wr_addr   = count[ADDR_WIDTH-1:0];
  assign last_word = (wr_addr == len_q);
  // The triggering cycle in ARMED is itself a capture cycle.
  assign do_write  = wr & (((state == StArmed) & trig) | (state == StCapture));
  assign unused_ctrl = ^ctrl_r;

  always_comb begin
    status_d                 = '0;
    status_d[ADDR_WIDTH:0]   = count;
    status_d[DONE]           = (state == StDone);
    status_d[ARMED]          = (state == StArmed);
    status_d[CAPT]           = (state == StCapture);
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      ctrl_r    <= '0;
      arm_d     <= 1'b0;
      state     <= StIdle;
      len_q     <= '0;
      count     <= '0;
      bram_addr <= '0;
      bram_data <= '0;
      bram_we   <= 1'b0;
      status    <= '0;
    end else begin
      ctrl_r  <= ctrl;
      arm_d   <= ctrl_r[ARM];
      status  <= status_d;
      bram_we <= 1'b0;
      if (arm_rise) begin
        // Re-arming aborts whatever is in flight.
        state <= StArmed;
        len_q <= len_m1;
        count <= '0;
      end else begin
        if (do_write) begin
          bram_we   <= 1'b1;
          bram_addr <= wr_addr;
          bram_data <= din;
          count     <= count + CountOne;
        end
        case (state)
          StArmed: begin
            if (trig) state <= (do_write && last_word) ? StDone : StCapture;
          end
          StCapture: begin
            if (do_write && last_word) state <= StDone;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snapshot_capture_ctrl.sv
// Directed plus randomized bench for snapshot_capture_ctrl with a transaction-level model.
module tb_snapshot_capture_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 4;
  localparam int unsigned HIST = 4096;

  logic          user_clk = 1'b0;
  logic          user_rst = 1'b1;
  logic [31:0]   ctrl     = '0;
  logic [DW-1:0] din      = '0;
  logic          we_in    = 1'b0;
  logic          trig_in  = 1'b0;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_data;
  logic          bram_we;
  logic [31:0]   status;

  snapshot_capture_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .user_clk (user_clk),
    .user_rst (user_rst),
    .ctrl     (ctrl),
    .din      (din),
    .we_in    (we_in),
    .trig_in  (trig_in),
    .bram_addr(bram_addr),
    .bram_data(bram_data),
    .bram_we  (bram_we),
    .status   (status)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    int            e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           obs_q[$];
  wr_t           exp_q[$];
  int            edge_n = 0;
  int            n_vec  = 0;
  int            n_err  = 0;
  logic          s_we   [HIST];
  logic          s_trig [HIST];
  logic [DW-1:0] s_din  [HIST];
  logic [31:0]   stat_hist[HIST];

  always @(posedge user_clk) edge_n <= edge_n + 1;

  // Writes become visible after edge e; record them mid-cycle.
  always @(negedge user_clk) begin
    if (edge_n < HIST) stat_hist[edge_n] = status;
    if (bram_we === 1'b1) obs_q.push_back('{e: edge_n, a: bram_addr, d: bram_data});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, sampled at the next rising edge.
  task automatic tick(input logic w, input logic t);
    we_in   = w;
    trig_in = t;
    din     = {$urandom, $urandom};
    s_we[edge_n + 1]   = w;
    s_trig[edge_n + 1] = t;
    s_din[edge_n + 1]  = din;
    @(posedge user_clk);
    #1;
  endtask

  // Arm seen by ctrl_r at edge a; trigger sampled from edge a+2. Appends the writes expected
  // at edges a+2..s-1 and returns the status visible after edge s.
  task automatic model(input int a, input int s, input int len, input bit frc, input bit swt,
                       output logic [31:0] st);
    bit started = 0;
    int n = 0;
    for (int k = a + 2; k < s; k++) begin
      if (!started && (s_trig[k] || swt)) started = 1;
      if (started && n <= len && (s_we[k] || frc)) begin
        exp_q.push_back('{e: k, a: n[AW-1:0], d: s_din[k]});
        n++;
      end
    end
    if (n == len + 1)  st = 32'h8000_0000 | 32'(n);
    else if (started)  st = 32'h2000_0000 | 32'(n);
    else               st = 32'h4000_0000;
  endtask

  task automatic check_writes(input string tag);
    check({tag, ".nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check({tag, ".edge"}, 64'(obs_q[i].e), 64'(exp_q[i].e));
      check({tag, ".addr"}, 64'(obs_q[i].a), 64'(exp_q[i].a));
      check({tag, ".data"}, obs_q[i].d, exp_q[i].d);
    end
  endtask

  task automatic disarm();
    ctrl = '0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int          a;
    int          a2;
    logic [31:0] st;

    // Reset and idle: triggers must be ignored.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("rst.status", 64'(status), 64'h0);
    check("rst.we", 64'(bram_we), 64'h0);
    user_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, i[0]);
      check("idle.status", 64'(status), 64'h0);
      check("idle.we", 64'(bram_we), 64'h0);
    end
    check("idle.nwr", 64'(obs_q.size()), 64'h0);

    // Software-trigger full-depth capture.
    disarm();
    a = edge_n + 1;
    ctrl = 32'h000F_0003;
    for (int i = 0; i < 22; i++) tick(1'b1, 1'b0);
    model(a, edge_n, 15, 1'b0, 1'b1, st);
    check_writes("full");
    check("full.status", 64'(status), 64'h8000_0010);

    // Hardware-trigger short capture, then a trigger in DONE.
    disarm();
    a = edge_n + 1;
    ctrl = 32'h0003_0001;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    check("hw.armed", 64'(stat_hist[a + 2]), 64'h4000_0000);
    model(a, edge_n, 3, 1'b0, 1'b0, st);
    check_writes("hw");
    check("hw.status", 64'(status), 64'h8000_0004);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    exp_q.delete();
    model(a, edge_n, 3, 1'b0, 1'b0, st);
    check_writes("hw.retrig");
    check("hw.retrig.status", 64'(status), 64'h8000_0004);

    // Gapped data, then the same with we_force.
    for (int f = 0; f < 2; f++) begin
      disarm();
      a = edge_n + 1;
      ctrl = (f == 0) ? 32'h0003_0003 : 32'h0003_0007;
      for (int i = 0; i < 14; i++) tick(((edge_n + 1 - a) % 2) == 0, 1'b0);
      model(a, edge_n, 3, f[0], 1'b1, st);
      check_writes(f == 0 ? "gap" : "force");
      check("gap.status", 64'(status), 64'h8000_0004);
      if (obs_q.size() == 4)
        check("gap.span", 64'(obs_q[3].e - obs_q[0].e), (f == 0) ? 64'd6 : 64'd3);
    end

    // Re-arm mid-capture with a new length.
    disarm();
    a = edge_n + 1;
    ctrl = 32'h000F_0003;
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b0);
    ctrl = 32'h000F_0002;
    tick(1'b1, 1'b0);
    a2 = edge_n + 1;
    ctrl = 32'h0007_0003;
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b0);
    model(a, a2 + 1, 15, 1'b0, 1'b1, st);
    model(a2, edge_n, 7, 1'b0, 1'b1, st);
    check_writes("rearm");
    check("rearm.armed", 64'(stat_hist[a2 + 2]), 64'h4000_0000);
    check("rearm.status", 64'(status), 64'h8000_0008);

    // Asynchronous reset mid-capture.
    disarm();
    ctrl = 32'h000F_0003;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    check("prerst.we", 64'(bram_we), 64'h1);
    user_rst = 1'b1;
    #1;
    check("midrst.we", 64'(bram_we), 64'h0);
    check("midrst.status", 64'(status), 64'h0);
    ctrl = '0;
    tick(1'b1, 1'b0);
    user_rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 6; i++) tick(1'b1, i[0]);
    check("postrst.status", 64'(status), 64'h0);
    check("postrst.nwr", 64'(obs_q.size()), 64'h0);
    exp_q.delete();
    a = edge_n + 1;
    ctrl = 32'h0001_0001;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    model(a, edge_n, 1, 1'b0, 1'b0, st);
    check_writes("postrst.cap");
    check("postrst.cap.status", 64'(status), 64'(st));

    // Randomized lengths, data-valid patterns and trigger timing.
    for (int r = 0; r < 6; r++) begin
      int          len;
      int          dly;
      bit          frc;
      logic [31:0] cv;
      len = $urandom_range(0, 15);
      dly = $urandom_range(0, 6);
      frc = 1'($urandom_range(0, 1));
      cv  = (32'(len) << 16) | 32'h1 | (frc ? 32'h4 : 32'h0);
      disarm();
      a = edge_n + 1;
      ctrl = cv;
      for (int i = 0; i < dly + 2; i++) tick($urandom_range(0, 3) != 0, 1'b0);
      tick($urandom_range(0, 1) != 0, 1'b1);
      for (int i = 0; i < 40; i++) begin
        if (i == 10) ctrl = cv ^ 32'h000A_0000;
        tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end
      model(a, edge_n, len, frc, 1'b0, st);
      check_writes("rand");
      check("rand.status", 64'(status), 64'(st));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
